strand_arbiter: RTL and testbench

STRAND_ARBITER -- requirements
Module: strand_arbiter

---
 rtl/strand_arbiter.sv | 126 ++++++++++++
 tb/tb_strand_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strand_arbiter.sv
// Four-strand round-robin issue arbiter with registered grant outputs.
// Vector-memory lane locking is compiled in only when STRAND_ARB_VEC_LOCK_EN is defined.
module strand_arbiter #(
  parameter int LANE_COUNT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] request_i,
  input  logic [3:0] vec_mem_i,
  input  logic [3:0] rollback_i,
  input  logic       stall_i,
  output logic [3:0] grant_o,
  output logic       issue_o,
  output logic [1:0] strand_id_o,
  output logic [3:0] lane_select_o
);

  localparam logic [3:0] LANE_LAST = 4'(LANE_COUNT - 1);

`ifdef STRAND_ARB_VEC_LOCK_EN
  typedef enum logic {ARB, VEC} state_e;
  state_e state_q, state_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{vec_mem_i, LANE_LAST};
`endif

  logic       issue_q, issue_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sid_q, sid_d;
  logic [3:0] lane_q, lane_d;
  logic [1:0] ptr_q, ptr_d;

  logic       found;
  logic [1:0] pick;
  logic       rb_cur;
  logic       do_arb;
  logic       clear;

  // Upward search from the priority pointer; strands being rolled back are ineligible.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && request_i[ptr_q + 2'(k)] && !rollback_i[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    issue_d = issue_q;
    grant_d = grant_q;
    sid_d   = sid_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    do_arb  = 1'b0;
    clear   = 1'b0;
    rb_cur  = issue_q && rollback_i[sid_q];
`ifdef STRAND_ARB_VEC_LOCK_EN
    state_d = state_q;
    if (state_q == VEC) begin
      // Flushing the locked strand aborts the transfer even while stalled.
      if (rb_cur) begin
        clear   = 1'b1;
        ptr_d   = sid_q + 2'd1;
        state_d = ARB;
      end else if (!stall_i) begin
        if (lane_q == LANE_LAST) do_arb = 1'b1;
        else                     lane_d = lane_q + 4'd1;
      end
    end else
`endif
    begin
      if (!stall_i)    do_arb = 1'b1;
      else if (rb_cur) clear  = 1'b1;
    end

    if (do_arb) begin
      lane_d  = 4'd0;
      issue_d = found;
      grant_d = found ? (4'b0001 << pick) : 4'b0000;
      sid_d   = found ? pick : 2'd0;
      if (found) ptr_d = pick + 2'd1;
`ifdef STRAND_ARB_VEC_LOCK_EN
      state_d = (found && vec_mem_i[pick]) ? VEC : ARB;
`endif
    end

    if (clear) begin
      issue_d = 1'b0;
      grant_d = 4'b0000;
      sid_d   = 2'd0;
      lane_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_q <= 1'b0;
      grant_q <= 4'b0000;
      sid_q   <= 2'd0;
      lane_q  <= 4'd0;
      ptr_q   <= 2'd0;
`ifdef STRAND_ARB_VEC_LOCK_EN
      state_q <= ARB;
`endif
    end else begin
      issue_q <= issue_d;
      grant_q <= grant_d;
      sid_q   <= sid_d;
      lane_q  <= lane_d;
      ptr_q   <= ptr_d;
`ifdef STRAND_ARB_VEC_LOCK_EN
      state_q <= state_d;
`endif
    end
  end

  assign issue_o       = issue_q;
  assign grant_o       = grant_q;
  assign strand_id_o   = sid_q;
  assign lane_select_o = lane_q;

endmodule

// File: tb/tb_strand_arbiter.sv
// Directed testbench for strand_arbiter; vector-lock scenarios run only when
// STRAND_ARB_VEC_LOCK_EN is defined for the build.
module tb_strand_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] request_i = 4'b0;
  logic [3:0] vec_mem_i = 4'b0;
  logic [3:0] rollback_i = 4'b0;
  logic       stall_i = 1'b0;
  logic [3:0] grant_o;
  logic       issue_o;
  logic [1:0] strand_id_o;
  logic [3:0] lane_select_o;

  int checks = 0;
  int failures = 0;

  strand_arbiter #(.LANE_COUNT(16)) dut (
    .clk(clk), .reset_n(reset_n), .request_i(request_i), .vec_mem_i(vec_mem_i),
    .rollback_i(rollback_i), .stall_i(stall_i), .grant_o(grant_o), .issue_o(issue_o),
    .strand_id_o(strand_id_o), .lane_select_o(lane_select_o)
  );

  always #5 clk = ~clk;

  // Packed view {issue, grant, strand_id, lane} of the outputs.
  function automatic logic [10:0] exp_out(input logic iss, input logic [1:0] sid, input logic [3:0] lane);
    logic [3:0] g;
    g = iss ? (4'b0001 << sid) : 4'b0000;
    return {iss, g, iss ? sid : 2'd0, lane};
  endfunction

  function automatic logic [10:0] obs();
    return {issue_o, grant_o, strand_id_o, lane_select_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    request_i = 4'b0; vec_mem_i = 4'b0; rollback_i = 4'b0; stall_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs(), 11'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    request_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs() !== exp_out(1'b1, seq[i], 4'd0)) begin
        failures++;
        $display("FAIL round_robin[%0d] got=%h want=%h", i, obs(), exp_out(1'b1, seq[i], 4'd0));
      end
    end
  endtask

  task automatic test_no_request();
    // Pointer is 1 after the round-robin sequence; idle cycles must not move it.
    request_i = 4'b0000;
    step();
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL idle got=%h want=%h", obs(), 11'd0);
    end
    step();
    request_i = 4'b1111;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd1, 4'd0)) begin
      failures++;
      $display("FAIL idle_ptr_hold got=%h want=%h", obs(), exp_out(1'b1, 2'd1, 4'd0));
    end
  endtask

  task automatic test_stall();
    do_reset();
    request_i = 4'b1111;
    step();
    stall_i = 1'b1;
    request_i = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== exp_out(1'b1, 2'd0, 4'd0)) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h want=%h", i, obs(), exp_out(1'b1, 2'd0, 4'd0));
      end
    end
    stall_i = 1'b0;
    request_i = 4'b1111;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd1, 4'd0)) begin
      failures++;
      $display("FAIL stall_release got=%h want=%h", obs(), exp_out(1'b1, 2'd1, 4'd0));
    end
  endtask

  task automatic test_rollback();
    // Strand 1 is shown; flushing it must clear the issue even under stall.
    stall_i = 1'b1;
    rollback_i = 4'b0010;
    step();
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL rollback_beats_stall got=%h want=%h", obs(), 11'd0);
    end
    rollback_i = 4'b0000;
    step();
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL rollback_stall_hold got=%h want=%h", obs(), 11'd0);
    end
    stall_i = 1'b0;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd2, 4'd0)) begin
      failures++;
      $display("FAIL rollback_resume got=%h want=%h", obs(), exp_out(1'b1, 2'd2, 4'd0));
    end
    rollback_i = 4'b1000;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd0, 4'd0)) begin
      failures++;
      $display("FAIL rollback_skip got=%h want=%h", obs(), exp_out(1'b1, 2'd0, 4'd0));
    end
    rollback_i = 4'b0000;
  endtask

  task automatic test_async_reset();
    request_i = 4'b1111;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs(), 11'd0);
    end
    reset_n = 1'b1;
    request_i = 4'b1000;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd3, 4'd0)) begin
      failures++;
      $display("FAIL after_reset got=%h want=%h", obs(), exp_out(1'b1, 2'd3, 4'd0));
    end
  endtask

`ifndef STRAND_ARB_VEC_LOCK_EN
  task automatic test_vec_ignored();
    do_reset();
    request_i = 4'b0011;
    vec_mem_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs() !== exp_out(1'b1, 2'(i % 2), 4'd0)) begin
        failures++;
        $display("FAIL vec_ignored[%0d] got=%h want=%h", i, obs(), exp_out(1'b1, 2'(i % 2), 4'd0));
      end
    end
    vec_mem_i = 4'b0000;
  endtask
`else
  task automatic test_vec_transfer();
    do_reset();
    request_i = 4'b0101;
    vec_mem_i = 4'b0100;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd0, 4'd0)) begin
      failures++;
      $display("FAIL vec_first got=%h want=%h", obs(), exp_out(1'b1, 2'd0, 4'd0));
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (obs() !== exp_out(1'b1, 2'd2, 4'(i))) begin
        failures++;
        $display("FAIL vec_lane[%0d] got=%h want=%h", i, obs(), exp_out(1'b1, 2'd2, 4'(i)));
      end
    end
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd0, 4'd0)) begin
      failures++;
      $display("FAIL vec_after got=%h want=%h", obs(), exp_out(1'b1, 2'd0, 4'd0));
    end
  endtask

  task automatic test_vec_stall();
    do_reset();
    request_i = 4'b0100;
    vec_mem_i = 4'b0100;
    for (int i = 0; i < 6; i++) step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== exp_out(1'b1, 2'd2, 4'd5)) begin
        failures++;
        $display("FAIL vec_stall[%0d] got=%h want=%h", i, obs(), exp_out(1'b1, 2'd2, 4'd5));
      end
    end
    stall_i = 1'b0;
    for (int i = 6; i < 16; i++) begin
      step();
      checks++;
      if (obs() !== exp_out(1'b1, 2'd2, 4'(i))) begin
        failures++;
        $display("FAIL vec_stall_lane[%0d] got=%h want=%h", i, obs(), exp_out(1'b1, 2'd2, 4'(i)));
      end
    end
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd2, 4'd0)) begin
      failures++;
      $display("FAIL vec_restart got=%h want=%h", obs(), exp_out(1'b1, 2'd2, 4'd0));
    end
  endtask

  task automatic test_vec_rollback();
    do_reset();
    request_i = 4'b0110;
    vec_mem_i = 4'b0010;
    for (int i = 0; i < 4; i++) step();
    rollback_i = 4'b0100;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd1, 4'd4)) begin
      failures++;
      $display("FAIL vec_other_rollback got=%h want=%h", obs(), exp_out(1'b1, 2'd1, 4'd4));
    end
    rollback_i = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    stall_i = 1'b1;
    rollback_i = 4'b0010;
    step();
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL vec_rollback got=%h want=%h", obs(), 11'd0);
    end
    stall_i = 1'b0;
    rollback_i = 4'b0000;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd2, 4'd0)) begin
      failures++;
      $display("FAIL vec_rollback_next got=%h want=%h", obs(), exp_out(1'b1, 2'd2, 4'd0));
    end
  endtask

  task automatic test_vec_reset();
    do_reset();
    request_i = 4'b0100;
    vec_mem_i = 4'b0100;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd2, 4'd9)) begin
      failures++;
      $display("FAIL vec_lane9 got=%h want=%h", obs(), exp_out(1'b1, 2'd2, 4'd9));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL vec_async_reset got=%h want=%h", obs(), 11'd0);
    end
    reset_n = 1'b1;
    request_i = 4'b1000;
    vec_mem_i = 4'b0000;
    step();
    checks++;
    if (obs() !== exp_out(1'b1, 2'd3, 4'd0)) begin
      failures++;
      $display("FAIL vec_after_reset got=%h want=%h", obs(), exp_out(1'b1, 2'd3, 4'd0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_no_request();
    test_stall();
    test_rollback();
    test_async_reset();
`ifndef STRAND_ARB_VEC_LOCK_EN
    test_vec_ignored();
`else
    test_vec_transfer();
    test_vec_stall();
    test_vec_rollback();
    test_vec_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
